// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM encoding and default
// frame timing, common to the receiver and transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= 2'b11;
    else       ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling, 8N1-style framing,
// one-cycle data_valid / frame_err pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state, state_n;
  logic [CW-1:0]        baud, baud_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 dv_n, fe_n;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RxD),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      data       <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (baud == HALF_END) begin
          baud_n  = '0;
          // line back high at mid start bit: a glitch
          state_n = rx_s ? IDLE : DATA;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      DATA: begin
        if (baud == BIT_END) begin
          baud_n  = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          bit_n   = bit_cnt + BW'(1);
          if (bit_cnt == BIT_LAST) state_n = STOP;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      STOP: begin
        if (baud == BIT_END) begin
          baud_n = '0;
          if (rx_s) begin
            data_n  = shift;
            dv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
// Frame table plus hand sequences for glitch, break, reset, latency.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dv_cnt = 0;
  int fe_cnt = 0;
  int both = 0;
  int longp = 0;
  int dv_cyc = 0;
  logic [7:0] last_data = '0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;

  always @(posedge clk) begin
    #1;
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      last_data = data;
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both++;
    if ((prev_dv && data_valid) || (prev_fe && frame_err))
      longp++;
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  int total = 0;
  int pass = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // bit period given in tenths of a clock to allow skew
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int p10);
    int n;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      RxD = 1'b0;
      else if (k == 9) RxD = stop;
      else             RxD = b[k-1];
      n = ((k + 1) * p10 + 5) / 10 - (k * p10 + 5) / 10;
      ticks(n);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         p10;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int d0, f0, t0;
    logic [7:0] keep;

    vecs[0] = '{8'hA5, 160, 0, 8'hA5};
    vecs[1] = '{8'h3C, 160, 8, 8'h3C};
    vecs[2] = '{8'h00, 166, 8, 8'h00};
    vecs[3] = '{8'hFF, 154, 8, 8'hFF};
    vecs[4] = '{8'hFF, 166, 8, 8'hFF};
    vecs[5] = '{8'h00, 154, 8, 8'h00};

    ticks(3);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_fe", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    ticks(5);

    for (int i = 0; i < 6; i++) begin
      d0 = dv_cnt;
      f0 = fe_cnt;
      send_frame(vecs[i].b, 1'b1, vecs[i].p10);
      ticks(vecs[i].gap);
      chk($sformatf("v%0d_dv", i), 32'(dv_cnt - d0), 32'd1);
      chk($sformatf("v%0d_fe", i), 32'(fe_cnt - f0), 32'd0);
      chk($sformatf("v%0d_data", i), 32'(last_data),
          32'(vecs[i].exp));
    end
    chk("tbl_out_data", 32'(data), 32'h00);

    // short low glitch on idle line
    ticks(10);
    d0 = dv_cnt;
    f0 = fe_cnt;
    RxD = 1'b0;
    ticks(4);
    chk("gl_busy_hi", 32'(busy), 32'd1);
    RxD = 1'b1;
    ticks(20);
    chk("gl_busy_lo", 32'(busy), 32'd0);
    chk("gl_dv", 32'(dv_cnt - d0), 32'd0);
    chk("gl_fe", 32'(fe_cnt - f0), 32'd0);

    // bad stop bit, line held low 40 cycles
    send_frame(8'h3C, 1'b1, 160);
    ticks(8);
    keep = data;
    d0 = dv_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 160);
    ticks(24);
    chk("fe_cnt", 32'(fe_cnt - f0), 32'd1);
    chk("fe_dv", 32'(dv_cnt - d0), 32'd0);
    chk("fe_data", 32'(data), 32'(keep));
    chk("fe_busy_hold", 32'(busy), 32'd1);
    RxD = 1'b1;
    ticks(4);
    chk("fe_busy_lo", 32'(busy), 32'd0);

    // reset in bit 3 of 0xFF
    ticks(10);
    RxD = 1'b0;
    ticks(CPB);
    RxD = 1'b1;
    ticks(4 * CPB + 8 - CPB);
    chk("rs_mid_busy", 32'(busy), 32'd1);
    d0 = dv_cnt;
    f0 = fe_cnt;
    reset = 1'b1;
    tick();
    chk("rs_data", 32'(data), 32'h0);
    chk("rs_dv", 32'(data_valid), 32'h0);
    chk("rs_fe", 32'(frame_err), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    ticks(200);
    chk("rs_no_dv", 32'(dv_cnt - d0), 32'd0);
    chk("rs_no_fe", 32'(fe_cnt - f0), 32'd0);
    send_frame(8'h81, 1'b1, 160);
    ticks(8);
    chk("rs_81_dv", 32'(dv_cnt - d0), 32'd1);
    chk("rs_81_data", 32'(data), 32'h81);

    // start edge to data_valid: 2 + 152 + 1 cycles
    ticks(10);
    t0 = cyc;
    d0 = dv_cnt;
    send_frame(8'h5A, 1'b1, 160);
    ticks(8);
    chk("lat_dv", 32'(dv_cnt - d0), 32'd1);
    chk("lat_cycles", 32'(dv_cyc - t0), 32'd155);
    chk("lat_data", 32'(data), 32'h5A);

    chk("dv_fe_overlap", 32'(both), 32'd0);
    chk("pulse_width", 32'(longp), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
